traveler_cmd_scheduler: RTL
===========================

Name: traveler_cmd_scheduler

Overview:
- Sits between the operation command sources and the UART transmitter that talks to the game machine.
- Accepts one-cycle command pulses from the button front-end and valid/ready commands from an automatic script source, and queues them in a small FIFO.
- Sends one command at a time, waits for the machine's acknowledge or a timeout, then enforces an inter-command gap.

Parameters:
- FIFO_DEPTH, 4, command queue entries (power of 2, ≥2)
- GAP_CYCLES, 1000000, idle cycles after each completed command (10 ms at 100 MHz)
- ACK_TIMEOUT, 50000000, cycles to wait for acknowledge before abandoning (0.5 s)
- CNT_W, 26, width of the shared gap/timeout counter (must hold max(GAP_CYCLES, ACK_TIMEOUT))

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- man_data  in  8  button command bus; a command is present in any cycle where [1:0]==2'b10 and [6:2]!=0
- auto_valid  in  1  script command valid
- auto_data  in  8  script command byte, same format as man_data
- auto_ready  out  1  scheduler accepts auto_data this cycle
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts byte
- ack_valid  in  1  one-cycle pulse: machine acknowledged the last command
- busy  out  1  high whenever state!=IDLE or FIFO not empty
- timeout_err  out  1  sticky, set on acknowledge timeout; cleared when next command is popped
- drop_cnt  out  8  saturating count of discarded commands

Behaviour:
- Reset (async, rst_n=0) clears all state:
  - tx_valid=0, tx_data=0, auto_ready=0, busy=0, timeout_err=0, drop_cnt=0.
  - FIFO emptied, state=IDLE, counter=0.
  - Reset mid-transfer abandons the command without retransmission.
- Valid command: bits [1:0]==2'b10 and bits [6:2] non-zero. Bit 7 is don't-care and is forced to 0 when enqueued.
- Enqueue arbitration, one write per cycle:
  - Manual has priority. If man_data is valid and the FIFO is not full, it is enqueued; auto_ready=0 that cycle.
  - Otherwise auto_ready = !full. Auto handshake completes when auto_valid && auto_ready.
  - An invalid auto byte is accepted, discarded, and drop_cnt is incremented.
  - A valid man_data while full is dropped and drop_cnt is incremented. The button front-end holds the bus for one cycle only, so there is no backpressure.
  - Invalid man_data (opcode 0) is ignored and not counted.
  - drop_cnt saturates at 255.
- Registered outputs: auto_ready and tx_valid are registered-free combinational decodes of registered state (no input-to-output paths except auto_ready←man_data).
- FSM states:
  - IDLE: if FIFO not empty, go to SEND and present the head. Entry into SEND takes 1 cycle after the first enqueue into an empty FIFO.
  - SEND: tx_valid=1, tx_data=head, held stable until tx_ready. On tx_ready: pop FIFO, clear timeout_err, counter=0, go to WAIT_ACK.
  - WAIT_ACK: counter increments every cycle.
    - ack_valid: counter=0, go to GAP.
    - Else if counter==ACK_TIMEOUT-1: timeout_err=1, counter=0, go to GAP.
    - ack_valid in the timeout cycle counts as an ack (no error).
    - ack_valid outside WAIT_ACK is ignored.
  - GAP: counter increments; at counter==GAP_CYCLES-1, go to IDLE.
- Throughput: minimum period between tx_valid rises is 1+1+GAP_CYCLES+1 cycles (ack in the first WAIT_ACK cycle).
- FIFO simultaneous push and pop in the same cycle are both honoured; full is not asserted by that cycle.
- FIFO pointers wrap modulo FIFO_DEPTH; the count uses log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package traveler_cmd_pkg: CHAN_OP=2'b10; opcode field [6:2]; OP_GET=5'b00001, OP_PUT=5'b00010, OP_INTERACT=5'b00100, OP_MOVE=5'b01000, OP_THROW=5'b10000; FSM state encoding.
- One sub-module, traveler_cmd_fifo: synchronous FIFO, 8-bit wide, parameter DEPTH, with push/pop/full/empty/head, async active-low reset.

Test Plan:
- Single command:
  - Stimulus: man_data=8'h06 (GET) for 1 cycle; tx_ready=1; ack after 5 cycles.
  - Response: tx_data=8'h06, tx_valid for 1 cycle exactly 2 cycles later; busy drops GAP_CYCLES cycles after the ack.
- Simultaneous sources:
  - Stimulus: man_data=8'h0A and auto_valid=1 with auto_data=8'h22 in the same cycle.
  - Response: auto_ready=0 that cycle; both bytes are sent in order 8'h0A then 8'h22.
- Overflow:
  - Stimulus: 6 manual commands while tx_ready=0, FIFO_DEPTH=4.
  - Response: drop_cnt=2; later bytes transmitted match the first 4 in order; auto_ready=0 while full.
- Timeout (ACK_TIMEOUT=20, GAP_CYCLES=5 for the bench):
  - Stimulus: no ack.
  - Response: timeout_err=1 exactly 20 cycles after the pop; it clears on the next pop.
  - Ack in the timeout cycle gives timeout_err=0.
- Invalid input:
  - Stimulus: man_data=8'h02, then auto_data=8'h01 with auto_valid=1.
  - Response: nothing transmitted; drop_cnt=1 (auto only).
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously during WAIT_ACK with 2 entries queued.
  - Response: outputs take reset values immediately; no transmission after release until a new command arrives.

Source files
------------

// File: rtl/traveler_cmd_pkg.sv
// Shared constants, state encoding and command decode for the traveler
// command scheduler.
package traveler_cmd_pkg;

  localparam logic [1:0] CHAN_OP     = 2'b10;
  localparam logic [4:0] OP_GET      = 5'b00001;
  localparam logic [4:0] OP_PUT      = 5'b00010;
  localparam logic [4:0] OP_INTERACT = 5'b00100;
  localparam logic [4:0] OP_MOVE     = 5'b01000;
  localparam logic [4:0] OP_THROW    = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

  function automatic logic cmd_ok(input logic [6:0] b);
    return (b[1:0] == CHAN_OP) && (b[6:2] != 5'd0);
  endfunction

endpackage

// File: rtl/traveler_cmd_fifo.sv
// Byte-wide synchronous command queue; push and pop may share a cycle.
// Pointers wrap modulo DEPTH, the count carries one extra bit.
module traveler_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/traveler_cmd_scheduler.sv
// Queues manual and scripted commands and paces them to the UART:
// one byte in flight, wait for ack or timeout, then a fixed idle gap.
module traveler_cmd_scheduler
  import traveler_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_CYCLES  = 1000000,
  parameter int ACK_TIMEOUT = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] man_data,
  input  logic       auto_valid,
  input  logic [7:0] auto_data,
  output logic       auto_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic       ack_valid,
  output logic       busy,
  output logic       timeout_err,
  output logic [7:0] drop_cnt
);

  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             err_n;
  logic             live;
  logic             man_ok;
  logic             auto_ok;
  logic             auto_fire;
  logic             push;
  logic             pop;
  logic             drop;
  logic [7:0]       din;
  logic [7:0]       head;
  logic             full;
  logic             empty;

  assign man_ok     = cmd_ok(man_data[6:0]);
  assign auto_ok    = cmd_ok(auto_data[6:0]);
  // live keeps auto_ready low until the first clock after reset
  assign auto_ready = live && !full && !man_ok;
  assign auto_fire  = auto_valid && auto_ready;
  assign push       = (man_ok && !full) || (auto_fire && auto_ok);
  assign drop       = (man_ok && full) || (auto_fire && !auto_ok);
  assign din        = man_ok ? (man_data & 8'h7F) : (auto_data & 8'h7F);

  assign tx_valid = (state == ST_SEND);
  assign tx_data  = tx_valid ? head : 8'h00;
  assign busy     = (state != ST_IDLE) || !empty;

  traveler_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = timeout_err;
    pop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!empty) state_n = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          pop     = 1'b1;
          err_n   = 1'b0;
          cnt_n   = '0;
          state_n = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_valid) begin
          cnt_n   = '0;
          state_n = ST_GAP;
        end else if (cnt == ACK_LAST) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = ST_GAP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      timeout_err <= 1'b0;
      drop_cnt    <= 8'h00;
      live        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      timeout_err <= err_n;
      live        <= 1'b1;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'h01;
    end
  end

endmodule
